// File: rtl/chidx_buffer_pkg.sv
//============================================================================
// Module   : chidx_buffer_pkg
// Brief    : shared read-FSM state encoding and default buffer geometry
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package chidx_buffer_pkg;

  localparam int c_IDX_WIDTH = 16;
  localparam int c_NUM_ROWS  = 16;
  localparam int c_ROW_DEPTH = 16;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_LOAD   = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/chidx_row_ctrl.sv
//============================================================================
// Module   : chidx_row_ctrl
// Brief    : per-row fill counts, append/clear arbitration, sticky overflow
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module chidx_row_ctrl
  import chidx_buffer_pkg::*;
#(
  parameter int NUM_ROWS  = c_NUM_ROWS,
  parameter int ROW_DEPTH = c_ROW_DEPTH,
  parameter int ROW_AW    = $clog2(NUM_ROWS),
  parameter int CNT_W     = $clog2(ROW_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_valid,
  input  logic [ROW_AW-1:0] wr_row,
  input  logic              clr_valid,
  input  logic [ROW_AW-1:0] clr_row,
  input  logic              ovf_clr,
  input  logic [ROW_AW-1:0] rd_row,
  output logic              wr_ready,
  output logic              wr_fire,
  output logic [CNT_W-2:0]  wr_ptr,
  output logic [CNT_W-1:0]  rd_count,
  output logic              ovf
);

  localparam logic [CNT_W-1:0] c_FULL = CNT_W'(ROW_DEPTH);

  logic [CNT_W-1:0] w_count [NUM_ROWS];
  logic [CNT_W-1:0] w_wr_count;
  logic             w_full;
  logic             w_clr_hit;
  logic             w_ovf_set;
  logic             r_ovf;

  assign w_wr_count = w_count[wr_row];
  assign w_full     = (w_wr_count == c_FULL);
  assign w_clr_hit  = clr_valid && (clr_row == wr_row);

  // A clear of the target row refuses the append outright; it is not an overflow.
  assign wr_ready  = !w_full && !w_clr_hit;
  assign wr_fire   = wr_valid && wr_ready;
  assign wr_ptr    = w_wr_count[CNT_W-2:0];
  assign rd_count  = w_count[rd_row];
  assign w_ovf_set = wr_valid && w_full && !w_clr_hit;

  generate
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_cnt <= '0;
        end else if (clr_valid && (clr_row == ROW_AW'(r))) begin
          r_cnt <= '0;
        end else if (wr_fire && (wr_row == ROW_AW'(r))) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_count[r] = r_cnt;
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf = r_ovf;

endmodule

`default_nettype wire

// File: rtl/chidx_buffer.sv
//============================================================================
// Module   : chidx_buffer
// Brief    : per-row channel-index store with whole-row streaming read-out
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module chidx_buffer
  import chidx_buffer_pkg::*;
#(
  parameter int IDX_WIDTH = c_IDX_WIDTH,
  parameter int NUM_ROWS  = c_NUM_ROWS,
  parameter int ROW_DEPTH = c_ROW_DEPTH,
  parameter int ROW_AW    = $clog2(NUM_ROWS),
  parameter int CNT_W     = $clog2(ROW_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ROW_AW-1:0]    wr_row,
  input  logic [IDX_WIDTH-1:0] wr_idx,
  input  logic                 clr_valid,
  input  logic [ROW_AW-1:0]    clr_row,
  input  logic                 rd_start,
  input  logic [ROW_AW-1:0]    rd_row,
  output logic                 rd_busy,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [IDX_WIDTH-1:0] rd_idx,
  output logic                 rd_last,
  output logic                 rd_done,
  output logic [CNT_W-1:0]     rd_count,
  output logic                 ovf,
  input  logic                 ovf_clr
);

  localparam int c_PTR_W = CNT_W - 1;

  logic               w_wr_fire;
  logic [c_PTR_W-1:0] w_wr_ptr;

  chidx_row_ctrl #(
    .NUM_ROWS  (NUM_ROWS),
    .ROW_DEPTH (ROW_DEPTH),
    .ROW_AW    (ROW_AW),
    .CNT_W     (CNT_W)
  ) u_row_ctrl (
    .clk       (clk),
    .rstn      (rstn),
    .wr_valid  (wr_valid),
    .wr_row    (wr_row),
    .clr_valid (clr_valid),
    .clr_row   (clr_row),
    .ovf_clr   (ovf_clr),
    .rd_row    (rd_row),
    .wr_ready  (wr_ready),
    .wr_fire   (w_wr_fire),
    .wr_ptr    (w_wr_ptr),
    .rd_count  (rd_count),
    .ovf       (ovf)
  );

  // Contents are only meaningful below the row's count, so no reset is needed.
  logic [IDX_WIDTH-1:0] r_mem [NUM_ROWS][ROW_DEPTH];

  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[wr_row][w_wr_ptr] <= wr_idx;
    end
  end

  rd_state_e            r_state, w_state_nxt;
  logic [ROW_AW-1:0]    r_row,   w_row_nxt;
  logic [CNT_W-1:0]     r_len,   w_len_nxt;
  logic [c_PTR_W-1:0]   r_ptr,   w_ptr_nxt;
  logic [IDX_WIDTH-1:0] r_idx,   w_idx_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 r_done,  w_done_nxt;
  logic [c_PTR_W-1:0]   w_ptr_inc;
  logic                 w_last_ptr;

  assign w_ptr_inc  = r_ptr + 1'b1;
  assign w_last_ptr = ({1'b0, r_ptr} == (r_len - 1'b1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= RD_IDLE;
      r_row   <= '0;
      r_len   <= '0;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_len   <= w_len_nxt;
      r_ptr   <= w_ptr_nxt;
      r_idx   <= w_idx_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_len_nxt   = r_len;
    w_ptr_nxt   = r_ptr;
    w_idx_nxt   = r_idx;
    w_valid_nxt = r_valid;
    w_done_nxt  = 1'b0;
    case (r_state)
      RD_IDLE: begin
        // Length is frozen here; later appends to this row are not streamed.
        if (rd_start) begin
          w_state_nxt = RD_LOAD;
          w_row_nxt   = rd_row;
          w_len_nxt   = rd_count;
          w_ptr_nxt   = '0;
        end
      end
      RD_LOAD: begin
        if (r_len == '0) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = RD_IDLE;
        end else begin
          w_idx_nxt   = r_mem[r_row][c_PTR_W'(0)];
          w_valid_nxt = 1'b1;
          w_state_nxt = RD_STREAM;
        end
      end
      RD_STREAM: begin
        if (r_valid && rd_ready) begin
          if (w_last_ptr) begin
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = RD_IDLE;
          end else begin
            w_ptr_nxt = w_ptr_inc;
            w_idx_nxt = r_mem[r_row][w_ptr_inc];
          end
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_state_nxt = RD_IDLE;
      end
    endcase
  end

  assign rd_busy  = (r_state != RD_IDLE);
  assign rd_valid = r_valid;
  assign rd_idx   = r_idx;
  assign rd_last  = r_valid && w_last_ptr;
  assign rd_done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_chidx_buffer.sv
//============================================================================
// Module   : tb_chidx_buffer
// Brief    : directed vector table plus hand sequences for chidx_buffer
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_chidx_buffer;

  logic        clk;
  logic        rstn;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_row;
  logic [15:0] wr_idx;
  logic        clr_valid;
  logic [3:0]  clr_row;
  logic        rd_start;
  logic [3:0]  rd_row;
  logic        rd_busy;
  logic        rd_valid;
  logic        rd_ready;
  logic [15:0] rd_idx;
  logic        rd_last;
  logic        rd_done;
  logic [4:0]  rd_count;
  logic        ovf;
  logic        ovf_clr;

  int errors = 0;
  int checks = 0;

  chidx_buffer dut (
    .clk       (clk),
    .rstn      (rstn),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_row    (wr_row),
    .wr_idx    (wr_idx),
    .clr_valid (clr_valid),
    .clr_row   (clr_row),
    .rd_start  (rd_start),
    .rd_row    (rd_row),
    .rd_busy   (rd_busy),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_idx    (rd_idx),
    .rd_last   (rd_last),
    .rd_done   (rd_done),
    .rd_count  (rd_count),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wv;
    logic [3:0]  wrow;
    logic [15:0] widx;
    logic        rs;
    logic [3:0]  rrow;
    logic        rr;
    logic        e_wrdy;
    logic        e_busy;
    logic        e_val;
    logic [15:0] e_idx;
    logic        e_last;
    logic        e_done;
    logic [4:0]  e_cnt;
    logic        e_ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic wv, input logic [3:0] wrow, input logic [15:0] widx,
                              input logic rs, input logic [3:0] rrow, input logic rr,
                              input logic e_wrdy, input logic e_busy, input logic e_val,
                              input logic [15:0] e_idx, input logic e_last, input logic e_done,
                              input logic [4:0] e_cnt, input logic e_ovf);
    vec_t v;
    v.wv = wv; v.wrow = wrow; v.widx = widx; v.rs = rs; v.rrow = rrow; v.rr = rr;
    v.e_wrdy = e_wrdy; v.e_busy = e_busy; v.e_val = e_val; v.e_idx = e_idx;
    v.e_last = e_last; v.e_done = e_done; v.e_cnt = e_cnt; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wr_valid = 0; wr_row = 0; wr_idx = 0; clr_valid = 0; clr_row = 0;
    rd_start = 0; rd_row = 0; rd_ready = 0; ovf_clr = 0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    idle_inputs();

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_rd_busy",  rd_busy,  0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_idx",   rd_idx,   0);
    chk("rst_rd_last",  rd_last,  0);
    chk("rst_rd_done",  rd_done,  0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_ovf",      ovf,      0);
    @(negedge clk);
    rstn = 1'b1;
    adv();

    // append/stream row 2, then back-pressured re-read of row 2
    tbl.push_back(mk(0,2,16'h0000, 0,2,0, 1,0,0,16'h0000,0,0,0,0));
    tbl.push_back(mk(1,2,16'h0003, 0,2,0, 1,0,0,16'h0000,0,0,0,0));
    tbl.push_back(mk(1,2,16'h0011, 0,2,0, 1,0,0,16'h0000,0,0,1,0));
    tbl.push_back(mk(1,2,16'h00F0, 0,2,0, 1,0,0,16'h0000,0,0,2,0));
    tbl.push_back(mk(0,2,16'h0000, 1,2,1, 1,0,0,16'h0000,0,0,3,0));
    tbl.push_back(mk(0,2,16'h0000, 0,2,1, 1,1,0,16'h0000,0,0,3,0));
    tbl.push_back(mk(0,2,16'h0000, 0,2,1, 1,1,1,16'h0003,0,0,3,0));
    tbl.push_back(mk(0,2,16'h0000, 0,2,1, 1,1,1,16'h0011,0,0,3,0));
    tbl.push_back(mk(0,2,16'h0000, 0,2,1, 1,1,1,16'h00F0,1,0,3,0));
    tbl.push_back(mk(0,2,16'h0000, 0,2,1, 1,0,0,16'h00F0,0,1,3,0));
    tbl.push_back(mk(0,2,16'h0000, 0,2,0, 1,0,0,16'h00F0,0,0,3,0));
    tbl.push_back(mk(0,2,16'h0000, 1,2,0, 1,0,0,16'h00F0,0,0,3,0));
    tbl.push_back(mk(0,2,16'h0000, 0,2,0, 1,1,0,16'h00F0,0,0,3,0));
    tbl.push_back(mk(0,2,16'h0000, 0,2,1, 1,1,1,16'h0003,0,0,3,0));
    tbl.push_back(mk(0,2,16'h0000, 0,2,0, 1,1,1,16'h0011,0,0,3,0));
    tbl.push_back(mk(0,2,16'h0000, 0,2,0, 1,1,1,16'h0011,0,0,3,0));
    tbl.push_back(mk(0,2,16'h0000, 0,2,1, 1,1,1,16'h0011,0,0,3,0));
    tbl.push_back(mk(0,2,16'h0000, 0,2,1, 1,1,1,16'h00F0,1,0,3,0));
    tbl.push_back(mk(0,2,16'h0000, 0,2,0, 1,0,0,16'h00F0,0,1,3,0));
    tbl.push_back(mk(0,2,16'h0000, 0,2,0, 1,0,0,16'h00F0,0,0,3,0));

    for (int i = 0; i < tbl.size(); i++) begin
      logic [26:0] act;
      logic [26:0] want;
      wr_valid = tbl[i].wv; wr_row = tbl[i].wrow; wr_idx = tbl[i].widx;
      rd_start = tbl[i].rs; rd_row = tbl[i].rrow; rd_ready = tbl[i].rr;
      mid();
      act  = {wr_ready, rd_busy, rd_valid, rd_idx, rd_last, rd_done, rd_count, ovf};
      want = {tbl[i].e_wrdy, tbl[i].e_busy, tbl[i].e_val, tbl[i].e_idx,
              tbl[i].e_last, tbl[i].e_done, tbl[i].e_cnt, tbl[i].e_ovf};
      chk($sformatf("vec[%0d] {wrdy,busy,val,idx,last,done,cnt,ovf}", i), 32'(act), 32'(want));
      adv();
    end
    idle_inputs();

    // fill row 5, overflow, ovf clear, set-wins
    wr_row = 5; wr_valid = 1;
    for (int i = 0; i < 16; i++) begin
      wr_idx = 16'(i) + 16'h0500;
      mid();
      chk($sformatf("fill_wr_ready[%0d]", i), wr_ready, 1);
      adv();
    end
    wr_valid = 0; rd_row = 5;
    mid();
    chk("full_wr_ready", wr_ready, 0);
    chk("full_count", rd_count, 16);
    adv();
    wr_valid = 1; wr_idx = 16'hDEAD;
    mid();
    chk("ovf_before", ovf, 0);
    adv();
    wr_valid = 0;
    mid();
    chk("ovf_set", ovf, 1);
    chk("ovf_count_held", rd_count, 16);
    adv();
    ovf_clr = 1;
    adv();
    ovf_clr = 0;
    mid();
    chk("ovf_cleared", ovf, 0);
    adv();
    wr_valid = 1; ovf_clr = 1;
    adv();
    wr_valid = 0; ovf_clr = 0;
    mid();
    chk("ovf_set_wins", ovf, 1);
    adv();
    ovf_clr = 1;
    adv();
    ovf_clr = 0;

    // stream the full row 5
    rd_start = 1; rd_ready = 1;
    adv();
    rd_start = 0;
    mid();
    chk("r5_load_valid", rd_valid, 0);
    adv();
    for (int i = 0; i < 16; i++) begin
      mid();
      chk($sformatf("r5_valid[%0d]", i), rd_valid, 1);
      chk($sformatf("r5_idx[%0d]", i), rd_idx, 32'h0500 + i);
      chk($sformatf("r5_last[%0d]", i), rd_last, (i == 15) ? 1 : 0);
      adv();
    end
    mid();
    chk("r5_done", rd_done, 1);
    chk("r5_valid_off", rd_valid, 0);
    adv();
    idle_inputs();

    // clear collides with append on row 1
    wr_row = 1; wr_valid = 1;
    for (int i = 0; i < 4; i++) begin
      wr_idx = 16'h0010 + 16'(i);
      adv();
    end
    wr_valid = 0; rd_row = 1;
    mid();
    chk("r1_count4", rd_count, 4);
    adv();
    clr_valid = 1; clr_row = 1; wr_valid = 1; wr_idx = 16'h00AA;
    mid();
    chk("clr_wr_ready", wr_ready, 0);
    adv();
    clr_valid = 0; wr_valid = 0;
    mid();
    chk("clr_count0", rd_count, 0);
    chk("clr_no_ovf", ovf, 0);
    adv();
    wr_valid = 1; wr_idx = 16'h0055;
    adv();
    wr_valid = 0;
    mid();
    chk("r1_count1", rd_count, 1);
    rd_start = 1; rd_ready = 1;
    adv();
    rd_start = 0;
    adv();
    mid();
    chk("r1_valid", rd_valid, 1);
    chk("r1_idx_entry0", rd_idx, 16'h0055);
    chk("r1_last", rd_last, 1);
    adv();
    mid();
    chk("r1_done", rd_done, 1);
    adv();
    idle_inputs();

    // zero-length read of empty row 7
    rd_row = 7; rd_start = 1; rd_ready = 1;
    mid();
    chk("r7_count", rd_count, 0);
    adv();
    rd_start = 0;
    mid();
    chk("r7_busy", rd_busy, 1);
    chk("r7_no_valid_t1", rd_valid, 0);
    chk("r7_no_done_t1", rd_done, 0);
    adv();
    mid();
    chk("r7_done_t2", rd_done, 1);
    chk("r7_no_valid_t2", rd_valid, 0);
    chk("r7_idle_t2", rd_busy, 0);
    adv();
    mid();
    chk("r7_done_pulse", rd_done, 0);
    adv();
    idle_inputs();

    // frozen length on row 0, rd_start while busy ignored
    wr_row = 0; wr_valid = 1; wr_idx = 16'h00A0;
    adv();
    wr_idx = 16'h00A1;
    adv();
    wr_valid = 0; rd_row = 0; rd_start = 1; rd_ready = 1;
    adv();
    rd_start = 0;
    mid();
    chk("r0_busy", rd_busy, 1);
    adv();
    wr_valid = 1; wr_idx = 16'h00A2; rd_start = 1;
    mid();
    chk("r0_beat0", rd_idx, 16'h00A0);
    chk("r0_beat0_last", rd_last, 0);
    adv();
    wr_valid = 0; rd_start = 0;
    mid();
    chk("r0_beat1", rd_idx, 16'h00A1);
    chk("r0_beat1_last", rd_last, 1);
    chk("r0_count3", rd_count, 3);
    adv();
    mid();
    chk("r0_done", rd_done, 1);
    chk("r0_valid_off", rd_valid, 0);
    adv();
    mid();
    chk("r0_restart_ignored", rd_busy, 0);
    chk("r0_count_after", rd_count, 3);
    adv();
    idle_inputs();

    // asynchronous reset during the second beat of row 3
    wr_row = 3; wr_valid = 1; wr_idx = 16'h0030;
    adv();
    wr_idx = 16'h0031;
    adv();
    wr_valid = 0; rd_row = 3; rd_start = 1; rd_ready = 1;
    adv();
    rd_start = 0;
    adv();
    mid();
    chk("r3_beat0", rd_idx, 16'h0030);
    adv();
    #2;
    chk("r3_beat1_pre_rst", rd_idx, 16'h0031);
    rstn = 1'b0;
    #1;
    chk("rst_mid_valid", rd_valid, 0);
    chk("rst_mid_busy", rd_busy, 0);
    chk("rst_mid_count3", rd_count, 0);
    rd_row = 5;
    #1;
    chk("rst_mid_count5", rd_count, 0);
    @(negedge clk);
    rstn = 1'b1;
    adv();
    rd_row = 3; rd_start = 1;
    adv();
    rd_start = 0;
    mid();
    chk("r3_post_busy", rd_busy, 1);
    chk("r3_post_no_valid", rd_valid, 0);
    adv();
    mid();
    chk("r3_post_done", rd_done, 1);
    chk("r3_post_no_valid2", rd_valid, 0);
    adv();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/chidx_buffer.md
# chidx_buffer

Parametrised per-row channel-index buffer for outlier-channel bookkeeping in the TENDER datapath. Writers append 16-bit channel indices into one of NUM_ROWS rows, each with a fill counter and full back-pressure. A read FSM streams a whole row back out under a valid/ready handshake, and individual rows can be cleared for reuse. It supersedes the write-only index store, which had no counts, no read-out and no overflow detection.

## Interface

Parameters:
- IDX_WIDTH, 16, width of one stored channel index
- NUM_ROWS, 16, number of rows (power of two, ≥2)
- ROW_DEPTH, 16, entries per row (power of two, ≥2)
- ROW_AW, $clog2(NUM_ROWS), row address width (derived)
- CNT_W, $clog2(ROW_DEPTH)+1, fill-count width (derived)

Ports:
- clk  in  1  clock, all state on rising edge
- rstn  in  1  reset; one clock; asynchronous, active-low
- wr_valid  in  1  append request
- wr_ready  out  1  append accepted this cycle when high with wr_valid
- wr_row  in  ROW_AW  target row
- wr_idx  in  IDX_WIDTH  channel index to append
- clr_valid  in  1  clear row clr_row (count→0)
- clr_row  in  ROW_AW  row to clear
- rd_start  in  1  begin streaming rd_row (sampled only in IDLE)
- rd_row  in  ROW_AW  row to stream
- rd_busy  out  1  read FSM not IDLE
- rd_valid  out  1  rd_idx valid
- rd_ready  in  1  consumer accepts beat
- rd_idx  out  IDX_WIDTH  streamed index
- rd_last  out  1  final beat of row, qualified by rd_valid
- rd_done  out  1  one-cycle pulse when a read finishes, including a zero-length read
- rd_count  out  CNT_W  fill count of rd_row (combinational view)
- ovf  out  1  sticky: append attempted to a full row
- ovf_clr  in  1  clears ovf

## Operation

- Storage array is not reset; per-row counts reset to 0. Valid contents are defined solely by count.
- Append: wr_ready = (count[wr_row] != ROW_DEPTH) && !(clr_valid && clr_row == wr_row). On wr_valid&&wr_ready: mem[wr_row][count] ← wr_idx, count += 1.
- wr_valid to a full row: dropped, ovf ← 1. ovf_clr in the same cycle as a new overflow: set wins.
- Clear: count[clr_row] ← 0 unconditionally. Clear and append to the same row in one cycle: clear wins and the append is refused via wr_ready=0, with no ovf.
- Read FSM states IDLE, LOAD, STREAM.
  - IDLE→LOAD on rd_start. Latch row into rd_row_q, latch len ← count[rd_row], ptr ← 0.
  - LOAD: if len==0, pulse rd_done and go to IDLE. Otherwise register rd_idx ← mem[row][0], rd_valid ← 1, and go to STREAM.
  - STREAM: on rd_valid&&rd_ready, if ptr==len-1 then drop rd_valid, pulse rd_done, go to IDLE. Otherwise ptr += 1 and rd_idx ← mem[row][ptr+1] in the same edge, with no bubble.
  - rd_idx and rd_valid hold while rd_ready is low.
- Length is frozen at rd_start. Appends to the row being read are stored but not streamed. A clear of that row does not abort the read; already-written entries are streamed unchanged.
- rd_last = rd_valid && ptr==len-1.

## Timing

- Reset values: wr_ready = 1 (all counts 0, no clear), rd_busy = 0, rd_valid = 0, rd_idx = 0, rd_last = 0, rd_done = 0, rd_count = 0, ovf = 0, FSM = IDLE.
- Append has 1-cycle latency to count; rd_count reflects it the next cycle.
- Read timing for rd_start at edge t:
  - rd_busy from t+1.
  - First rd_valid at t+2.
  - With rd_ready held high, N beats occupy t+2..t+N+1.
  - rd_done at t+N+2, FSM IDLE the same cycle.
  - Zero-length read: rd_done at t+2.
- rd_start while rd_busy is ignored.
- A read of a row written in the same cycle as rd_start uses the pre-write count.
- Reset mid-read returns to IDLE with rd_valid dropped immediately (asynchronous reset) and all counts zeroed.

## Structure

- Shared package: read FSM state enum (IDLE/LOAD/STREAM) and the default IDX_WIDTH/ROW_DEPTH/NUM_ROWS constants used by the quantiser side.
- One natural sub-module: chidx_row_ctrl, holding per-row counts, full/ready generation, the clear-versus-append arbitration and ovf.
- The read FSM and storage stay in the top.

## Test plan

- **Append and stream:** reset; append 0x0003, 0x0011, 0x00F0 to row 2, then rd_start row 2 with rd_ready=1 → rd_count=3; beats 0x0003, 0x0011, 0x00F0 on consecutive cycles starting 2 cycles after rd_start; rd_last on the third beat; rd_done the next cycle.
- **Back-pressure:** same row, rd_ready toggling 1,0,0,1,1 → each rd_idx holds through the stalls; exactly 3 beats accepted; no duplicates.
- **Full/overflow:** append ROW_DEPTH entries to row 5 → wr_ready=0 for row 5; one more wr_valid → ovf=1 and count stays 16; ovf_clr → ovf=0.
- **Clear collision:** clr_valid and wr_valid to row 1 in the same cycle with row 1 at count 4 → wr_ready=0, count=0, ovf stays 0; the next append lands at entry 0.
- **Zero-length and frozen length:** rd_start on empty row 7 → rd_done 2 cycles later with no rd_valid. Separately, start a read of row 0 with count 2, append during STREAM → only 2 beats, then rd_count=3.
- **Reset mid-read:** assert rstn=0 during the second beat → rd_valid, rd_busy and all counts are 0 immediately; after release, rd_start on that row → zero-length read.
